// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keycode capture block.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    localparam int unsigned KEYCODE_W = 16;
    localparam int unsigned BRK_BIT   = 15;
    localparam int unsigned EXT_BIT   = 8;

    // True when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    function automatic logic [KEYCODE_W-1:0] make_keycode(input logic       brk,
                                                          input logic       ext,
                                                          input logic [7:0] code);
        logic [KEYCODE_W-1:0] kc;
        kc          = '0;
        kc[7:0]     = code;
        kc[EXT_BIT] = ext;
        kc[BRK_BIT] = brk;
        return kc;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes the PS/2 pins and turns the glitch-filtered ps2_clk into a
// one-cycle falling-edge strobe.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_sync,
    output logic fall_strobe
);

    localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]       clk_sh;
    logic [1:0]       data_sh;
    logic             clk_filt;
    logic [CNT_W-1:0] cnt;
    logic             clk_sync;

    assign clk_sync  = clk_sh[1];
    assign data_sync = data_sh[1];

    // Filtered clock flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sh      <= 2'b11;
            data_sh     <= 2'b11;
            clk_filt    <= 1'b1;
            cnt         <= '0;
            fall_strobe <= 1'b0;
        end else begin
            clk_sh      <= {clk_sh[0], ps2_clk};
            data_sh     <= {data_sh[0], ps2_data};
            fall_strobe <= 1'b0;
            if (clk_sync == clk_filt) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
                cnt         <= '0;
                clk_filt    <= clk_sync;
                fall_strobe <= ~clk_sync;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_keycode_capture.sv
// PS/2 keyboard receiver: frames bytes, folds E0/F0 prefixes into a 16-bit
// key event word that holds until the next event.
module ps2_keycode_capture
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    output logic [KEYCODE_W-1:0] keycode,
    output logic                 key_valid,
    output logic                 frame_err
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_e    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          ext_pend;
    logic          brk_pend;
    logic [TO_W-1:0] to_cnt;
    logic          strobe;
    logic          data_sync;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .clk         (clk),
        .reset_n     (reset_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .data_sync   (data_sync),
        .fall_strobe (strobe)
    );

    // to_cnt counts cycles since the last strobe; the abort lands TIMEOUT_CYCLES after it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            to_cnt    <= '0;
            keycode   <= '0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            if (strobe) begin
                to_cnt <= TO_W'(1);
                case (state)
                    IDLE: begin
                        if (!data_sync) begin
                            bit_cnt <= '0;
                            state   <= DATA;
                        end
                    end
                    DATA: begin
                        shreg   <= {data_sync, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= data_sync;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (odd_parity_ok(shreg, par_bit) && data_sync) begin
                            if (shreg == PREFIX_EXT) begin
                                ext_pend <= 1'b1;
                            end else if (shreg == PREFIX_BRK) begin
                                brk_pend <= 1'b1;
                            end else begin
                                keycode   <= make_keycode(brk_pend, ext_pend, shreg);
                                key_valid <= 1'b1;
                                ext_pend  <= 1'b0;
                                brk_pend  <= 1'b0;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            ext_pend  <= 1'b0;
                            brk_pend  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state     <= IDLE;
                to_cnt    <= '0;
                frame_err <= 1'b1;
                ext_pend  <= 1'b0;
                brk_pend  <= 1'b0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode_capture.sv
// Bench for ps2_keycode_capture: drives PS/2 frames on the pins and checks
// every cycle against a frame-level model of the key event word.
`timescale 1ns/1ps
module tb_ps2_keycode_capture;

    localparam int unsigned F      = 8;
    localparam int unsigned T      = 400;
    localparam int unsigned KV_LAT = F + 3;      // pin fall of stop bit -> key_valid edge
    localparam int unsigned TO_LAT = F + 2 + T;  // last pin fall -> frame_err edge

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] keycode;
    logic        key_valid;
    logic        frame_err;

    int          n_cmp = 0;
    int          n_bad = 0;

    logic [15:0] exp_keycode = 16'h0000;
    logic        exp_kv      = 1'b0;
    logic        exp_fe      = 1'b0;
    bit          m_ext       = 1'b0;
    bit          m_brk       = 1'b0;

    always #5 clk = ~clk;

    ps2_keycode_capture #(
        .FILTER_LEN     (F),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keycode   (keycode),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("keycode", keycode, exp_keycode);
        chk("key_valid", 16'(key_valid), 16'(exp_kv));
        chk("frame_err", 16'(frame_err), 16'(exp_fe));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Frame-level model applied on the edge where the DUT should react to the stop bit.
    task automatic model_stop(input logic [7:0] b, input bit good);
        if (!good) begin
            exp_fe = 1'b1;
            m_ext  = 1'b0;
            m_brk  = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            exp_kv      = 1'b1;
            exp_keycode = (m_brk ? 16'h8000 : 16'h0000) | (m_ext ? 16'h0100 : 16'h0000)
                        | {8'h00, b};
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int h,
                             input bit glitch, input logic [7:0] b, input bit good);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (glitch && i == 3) begin
                tick(12);
                ps2_clk = 1'b0;
                tick(3);
                ps2_clk = 1'b1;
                tick(h - 15);
            end else begin
                tick(h);
            end
            ps2_clk = 1'b0;
            if (i == 10) begin
                repeat (KV_LAT) @(posedge clk);
                model_stop(b, good);
                @(posedge clk);
                exp_kv = 1'b0;
                exp_fe = 1'b0;
                tick(h - int'(KV_LAT) - 1);
            end else begin
                tick(h);
            end
            ps2_clk = 1'b1;
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par,
                                               input bit bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int h, input bit glitch, input int gap);
        send_bits(frame_bits(b, bad_par, bad_stop), 11, h, glitch, b, !bad_par && !bad_stop);
        ps2_data = 1'b1;
        tick(gap);
    endtask

    task automatic frame(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 25, 1'b0, 60);
    endtask

    initial begin
        logic [7:0] rb;
        int         sel;

        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(5);
        chk("lit_reset", keycode, 16'h0000);
        reset_n = 1'b1;
        tick(20);

        frame(8'h1C);
        chk("lit_make", keycode, 16'h001C);

        frame(8'hF0);
        chk("lit_after_f0", keycode, 16'h001C);
        frame(8'h1C);
        chk("lit_break", keycode, 16'h801C);

        frame(8'hE0);
        frame(8'hF0);
        frame(8'h75);
        chk("lit_ext_break", keycode, 16'h8175);
        frame(8'h75);
        chk("lit_plain_75", keycode, 16'h0075);

        frame(8'hF0);
        send_frame(8'h1C, 1'b1, 1'b0, 25, 1'b0, 60);
        chk("lit_parity_hold", keycode, 16'h0075);
        frame(8'h1C);
        chk("lit_parity_clear", keycode, 16'h001C);

        send_frame(8'h22, 1'b0, 1'b1, 25, 1'b0, 60);
        chk("lit_stop_hold", keycode, 16'h001C);

        send_frame(8'h34, 1'b0, 1'b0, 25, 1'b1, 60);
        chk("lit_glitch_frame", keycode, 16'h0034);

        // Idle glitch with data low: a leaked strobe would start a frame and time out.
        ps2_data = 1'b0;
        tick(5);
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(5);
        ps2_data = 1'b1;
        tick(T + 100);

        frame(8'hF0);
        send_bits(frame_bits(8'h5A, 1'b0, 1'b0), 5, 25, 1'b0, 8'h5A, 1'b1);
        ps2_data = 1'b1;
        repeat (TO_LAT - 25) @(posedge clk);
        exp_fe = 1'b1;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        @(posedge clk);
        exp_fe = 1'b0;
        tick(40);
        frame(8'h1C);
        chk("lit_timeout_next", keycode, 16'h001C);

        frame(8'hE0);
        frame(8'h6B);
        chk("lit_ext_make", keycode, 16'h016B);
        frame(8'hF0);
        send_bits(frame_bits(8'h5A, 1'b0, 1'b0), 5, 25, 1'b0, 8'h5A, 1'b1);
        tick(3);
        reset_n     = 1'b0;
        exp_keycode = 16'h0000;
        m_ext       = 1'b0;
        m_brk       = 1'b0;
        ps2_data    = 1'b1;
        tick(3);
        chk("lit_reset_mid", keycode, 16'h0000);
        reset_n = 1'b1;
        tick(30);
        frame(8'h1C);
        chk("lit_after_reset", keycode, 16'h001C);

        for (int n = 0; n < 50; n++) begin
            sel = int'($urandom_range(0, 9));
            rb  = 8'($urandom);
            if (sel == 0) rb = 8'hE0;
            else if (sel == 1) rb = 8'hF0;
            else if (sel == 2) rb = 8'hE1;
            send_frame(rb, $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0,
                       int'($urandom_range(20, 30)), $urandom_range(0, 3) == 0,
                       int'($urandom_range(20, 100)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_keycode_capture.md
# ps2_keycode_capture

Receives PS/2 keyboard frames on the raw ps2_clk/ps2_data pins, assembles scancodes including the 0xE0 (extended) and 0xF0 (break) prefixes, and presents the most recent key event as a stable 16-bit word. It sits directly upstream of the 16-bit software-facing PIO input port: keycode drives that port's in_port, which the Nios II polls over Avalon.

## Interface
- FILTER_LEN, 8: consecutive identical synchronized samples required before the filtered ps2_clk changes state.
- TIMEOUT_CYCLES, 50000: idle clk cycles with no filtered falling edge, inside a frame, before the frame is aborted (1 ms at 50 MHz).

- clk  input  1  system clock; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clk.
- ps2_data  input  1  raw PS/2 data pin, asynchronous to clk.
- keycode  output  16  last completed key event: [15] break, [14:9] zero, [8] extended, [7:0] scancode. Connects to the PIO in_port.
- key_valid  output  1  one-cycle pulse when keycode is updated.
- frame_err  output  1  one-cycle pulse on a parity, stop-bit or timeout failure.

## Operation
- ps2_clk and ps2_data each pass through a 2-flop synchronizer.
- Filtered clock: changes only after the synchronized ps2_clk has differed from it for FILTER_LEN consecutive cycles.
- A falling edge of the filtered clock is a one-cycle strobe that samples synchronized ps2_data.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a strobe, if data = 0 (start bit), clear the bit counter and go to DATA. If data = 1, ignore the strobe and stay in IDLE.
  - DATA: shift 8 bits, LSB first, into the byte register; after bit 7 go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: on the strobe, check that parity is odd over 8 data bits plus the parity bit, and that the stop bit = 1; then return to IDLE.
- Good byte:
  - 0xE0: set ext_pend.
  - 0xF0: set brk_pend.
  - Any other byte, including 0xE1: keycode <= {brk_pend, 6'b0, ext_pend, byte}; clear both pending flags; pulse key_valid.
- Bad parity or stop bit: drop the byte, clear both pending flags, pulse frame_err, go to IDLE. keycode is unchanged.
- Timeout: in any non-IDLE state, TIMEOUT_CYCLES cycles without a strobe abort the frame. Same actions as a bad frame: frame_err pulse, pending flags cleared, IDLE.
- keycode holds its value indefinitely between events. Software detects a new event by a change of value, so a repeated identical event is invisible to software; this is accepted.
- Reset (asynchronous, any time including mid-frame): keycode = 16'h0000, key_valid = 0, frame_err = 0, FSM = IDLE, pending flags = 0, timeout counter = 0, filtered clock = 1.

## Timing
- Pin to strobe: 2 synchronizer cycles + FILTER_LEN cycles after the pin's falling edge.
- Update: keycode and key_valid change in the cycle after the stop-bit strobe. key_valid is high for exactly that one cycle.
- The PIO adds one more register stage, so software sees the update 1 cycle after keycode changes.
- The timeout counter reloads on every strobe and on entry to IDLE. The abort fires on the cycle the count reaches TIMEOUT_CYCLES.
- A strobe and a timeout in the same cycle: the strobe wins; the timeout counter reloads.
- Throughput: PS/2 clock is 10-16.7 kHz, so frames are separated by more than 3000 clk cycles at 50 MHz. No back-pressure and no buffering; each new event overwrites keycode.

## Structure
- Package ps2_pkg holds:
  - the FSM state enum;
  - PREFIX_EXT = 8'hE0 and PREFIX_BRK = 8'hF0;
  - keycode bit positions: BRK_BIT = 15, EXT_BIT = 8.
- Sub-module ps2_line_filter: 2-flop synchronizer, FILTER_LEN glitch filter and falling-edge strobe for ps2_clk. ps2_data uses only the synchronizer.
- The top level contains the FSM, shift register, parity check, prefix flags and timeout counter.

## Test plan
- Reset mid-frame: assert reset_n low after 4 data bits -> keycode = 0000, FSM returns to IDLE. The next complete frame for 0x1C decodes correctly to 001C.
- Make code: frame 0x1C ('A', odd parity bit = 0) -> keycode = 16'h001C, one key_valid pulse, no frame_err.
- Break code: frames F0 then 1C -> no key_valid after F0; after 1C, keycode = 16'h801C with one pulse.
- Extended break: frames E0, F0, 75 (up arrow) -> keycode = 16'h8175. A following plain frame 0x75 gives 16'h0075.
- Parity error: frame 0x1C with parity bit = 1 -> frame_err pulse, keycode unchanged. A pending F0 from the previous frame is cleared, so a following 0x1C gives 001C.
- Glitch and timeout:
  - A 3-cycle low glitch on ps2_clk (FILTER_LEN = 8) -> no strobe.
  - Stop toggling after 5 bits -> frame_err exactly TIMEOUT_CYCLES cycles after the last strobe. The next full frame decodes correctly.
